mem_copy_engine: RTL

- Initiator-side master for the single-port 8-bit, 256-byte data memory.
- Drives memory address, write enable and write data; consumes the memory's combinational read data.
- Offloads two operations from the core: block copy (src→dst) and block fill (constant→dst).
- Sits between the control unit, which issues start/params and waits on done, and the data memory port. A mux outside this block selects this master while busy=1.

---
 rtl/mem_copy_engine.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// ============================================================================
// mem_copy_engine : byte-serial block copy / block fill master for an 8-bit memory
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] c_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_buf;
  logic [DW-1:0] r_fill;
  logic          r_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_fill  <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start && (len != '0)) begin
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            r_cnt  <= len;
            r_fill <= fill_val;
            r_mode <= mode;
          end
        end
        S_READ: begin
          r_buf <= mem_rdata;
          r_src <= r_src + c_ONE;
        end
        S_WRITE: begin
          r_dst <= r_dst + c_ONE;
          r_cnt <= r_cnt - c_ONE;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state only, so an async reset clears them at once.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_next = S_DONE;
          end else if (mode) begin
            w_next = S_WRITE;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_READ: begin
        busy     = 1'b1;
        mem_addr = r_src;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_addr  = r_dst;
        mem_wr_en = 1'b1;
        mem_wdata = r_mode ? r_fill : r_buf;
        if (r_cnt == c_ONE) begin
          w_next = S_DONE;
        end else if (r_mode) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_READ;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
